// File: rtl/fir_tx_pkg.sv
// fir_tx_pkg: shared definitions for the FIR output-side stream transmitter.
// Holds the transmitter FSM encoding and the default datapath widths that the
// AXI-Lite control block also uses when it programs data_length.
package fir_tx_pkg;

    // Transmitter FSM encoding; values are visible on the state_dbg port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fir_tx_state_e;

    // Default sample width and beat-counter width shared with the AXI-Lite block.
    localparam int FIR_TX_WIDTH = 32;
    localparam int FIR_TX_LEN_W = 32;

    // Two entries are the minimum that sustains one beat per cycle without a
    // combinational ready path from the stream side back to the FIR side.
    localparam int FIR_TX_DEPTH = 2;

endpackage

// File: rtl/fir_tx_buf.sv
// fir_tx_buf: small ring buffer between the FIR datapath and the stream port.
// Write at wrp, read at rdp, both wrapping DEPTH-1 -> 0. An occupancy counter
// provides full/empty. rd_data is the registered entry at rdp, so a sample
// written into an empty buffer only becomes visible on the following cycle.
module fir_tx_buf
    import fir_tx_pkg::*;
#(
    parameter int WIDTH = FIR_TX_WIDTH,
    parameter int DEPTH = FIR_TX_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrp;
    logic [PW-1:0]    rdp;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Protect the buffer even if a caller ignores full/empty.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign rd_data = mem[rdp];

    // Storage array; cleared on reset so the stream data port reads 0 after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wrp] <= push_data;
        end
    end

    // Write pointer advances on every accepted push and wraps at the last entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrp <= '0;
        end else if (do_push) begin
            wrp <= (wrp == PTR_LAST) ? '0 : wrp + PW'(1);
        end
    end

    // Read pointer advances on every pop and wraps at the last entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdp <= '0;
        end else if (do_pop) begin
            rdp <= (rdp == PTR_LAST) ? '0 : rdp + PW'(1);
        end
    end

    // Occupancy: up on push only, down on pop only, hold when both or neither.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_stream_tx.sv
// fir_stream_tx: AXI-Stream transmitter for the FIR engine output.
// Accepts FIR samples, buffers them in fir_tx_buf and emits a frame of
// data_length beats with sm_tlast on the final beat, then pulses done.
// Optional feature macro: FIR_TX_ERR_EN enables the sticky out-of-frame
// sample flag on err; without it err is tied to 0.
//
// Handshake semantics (both y_* and sm_* ports): a transfer happens on a
// rising clk edge where valid and ready are both 1. A source holds valid and
// its data stable until the transfer; ready may change freely. y_ready depends
// only on registered state, never combinationally on sm_tready.
module fir_stream_tx
    import fir_tx_pkg::*;
#(
    parameter int WIDTH = FIR_TX_WIDTH,
    parameter int DEPTH = FIR_TX_DEPTH,
    parameter int LEN_W = FIR_TX_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] data_length,
    input  logic             y_valid,
    input  logic [WIDTH-1:0] y_data,
    output logic             y_ready,
    output logic             sm_tvalid,
    input  logic             sm_tready,
    output logic [WIDTH-1:0] sm_tdata,
    output logic             sm_tlast,
    output logic             busy,
    output logic             done,
    output logic             err,
    output fir_tx_state_e    state_dbg
);

    fir_tx_state_e    state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] in_cnt;
    logic [LEN_W-1:0] out_cnt;
    logic             done_q;
    logic             buf_full;
    logic             buf_empty;
    logic             push;
    logic             pop;
    logic             last_beat;

    // Accept samples only inside a frame, with room, and until the frame is fully fed.
    assign y_ready   = (state == ST_RUN) & ~buf_full & (in_cnt < len_q);
    assign push      = y_valid & y_ready;

    assign sm_tvalid = ~buf_empty;
    assign pop       = sm_tvalid & sm_tready;

    // len_q >= 1 whenever the buffer holds data, so len_q - 1 never underflows here.
    assign last_beat = (out_cnt == len_q - LEN_W'(1));
    assign sm_tlast  = sm_tvalid & last_beat;

    assign busy      = (state != ST_IDLE);
    assign done      = done_q;
    assign state_dbg = state;

    fir_tx_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (y_data),
        .pop       (pop),
        .full      (buf_full),
        .empty     (buf_empty),
        .rd_data   (sm_tdata)
    );

    // Frame FSM with beat counters and the registered done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (data_length != '0) begin
                            state   <= ST_RUN;
                            len_q   <= data_length;
                            in_cnt  <= '0;
                            out_cnt <= '0;
                        end else begin
                            // Empty frame: report completion without entering RUN.
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (push) begin
                        in_cnt <= in_cnt + LEN_W'(1);
                    end
                    if (pop) begin
                        out_cnt <= out_cnt + LEN_W'(1);
                    end
                    if (pop && last_beat) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FIR_TX_ERR_EN
    logic start_accept;
    logic err_q;

    assign start_accept = (state == ST_IDLE) & start;
    assign err          = err_q;

    // Sticky flag for samples offered outside a frame or beyond its length;
    // such samples are never accepted because y_ready is low in those cases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (start_accept) begin
            err_q <= 1'b0;
        end else if (y_valid && ((state != ST_RUN) || (in_cnt == len_q))) begin
            err_q <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fir_stream_tx.sv
// tb_fir_stream_tx: directed bench for fir_stream_tx with a queue-based
// frame model checked every cycle plus hand-computed per-test expectations.
module tb_fir_stream_tx;

    localparam int W      = 32;
    localparam int DEPTH  = 2;
`ifdef FIR_TX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   data_length;
    logic          y_valid;
    logic [W-1:0]  y_data;
    logic          y_ready;
    logic          sm_tvalid;
    logic          sm_tready;
    logic [W-1:0]  sm_tdata;
    logic          sm_tlast;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    state_dbg;

    always #5 clk = ~clk;

    fir_stream_tx #(.WIDTH(W), .DEPTH(DEPTH), .LEN_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .data_length (data_length),
        .y_valid     (y_valid),
        .y_data      (y_data),
        .y_ready     (y_ready),
        .sm_tvalid   (sm_tvalid),
        .sm_tready   (sm_tready),
        .sm_tdata    (sm_tdata),
        .sm_tlast    (sm_tlast),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .state_dbg   (state_dbg)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame model (scoreboard) ----------------
    // A frame is "running" from an accepted start until its last beat leaves,
    // then one completion cycle. Accepted samples queue up in exp_q and leave
    // in order; the buffer can hold at most DEPTH samples.
    logic [W-1:0] exp_q[$];
    int           m_phase;   // 0 idle, 1 running, 2 completing
    logic [31:0]  m_len;
    logic [31:0]  m_in;
    logic [31:0]  m_out;
    logic         m_done;
    logic         m_err;
    int           cyc = 0;

    // Observation log for per-test literal checks.
    logic [W-1:0] obs_data[$];
    logic         obs_last[$];
    int           obs_cyc[$];
    int           done_cyc = -1;

    task automatic model_reset();
        exp_q.delete();
        m_phase = 0;
        m_len   = 0;
        m_in    = 0;
        m_out   = 0;
        m_done  = 0;
        m_err   = 0;
    endtask

    initial model_reset();

    // Compare on the falling edge, then advance the model over the coming rising edge.
    always @(negedge clk) begin
        logic exp_rdy, exp_vld, exp_lst, psh, pp;
        cyc++;
        if (!reset) model_reset();
        exp_rdy = (m_phase == 1) && (exp_q.size() < DEPTH) && (m_in < m_len);
        exp_vld = (exp_q.size() > 0);
        exp_lst = exp_vld && (m_out == m_len - 32'd1);
        chk("y_ready",   {31'd0, y_ready},   {31'd0, exp_rdy});
        chk("sm_tvalid", {31'd0, sm_tvalid}, {31'd0, exp_vld});
        chk("sm_tlast",  {31'd0, sm_tlast},  {31'd0, exp_lst});
        chk("busy",      {31'd0, busy},      {31'd0, (m_phase != 0)});
        chk("done",      {31'd0, done},      {31'd0, m_done});
        chk("err",       {31'd0, err},       {31'd0, m_err});
        if (exp_vld) chk("sm_tdata", sm_tdata, exp_q[0]);
        if (reset) begin
            if (sm_tvalid && sm_tready) begin
                obs_data.push_back(sm_tdata);
                obs_last.push_back(sm_tlast);
                obs_cyc.push_back(cyc);
            end
            if (done) done_cyc = cyc;
            psh = y_valid && exp_rdy;
            pp  = exp_vld && sm_tready;
            if (ERR_EN) begin
                if (m_phase == 0 && start) m_err = 1'b0;
                else if (y_valid && (m_phase != 1 || m_in == m_len)) m_err = 1'b1;
            end
            m_done = 1'b0;
            case (m_phase)
                0: if (start) begin
                    if (data_length != 0) begin
                        m_phase = 1; m_len = data_length; m_in = 0; m_out = 0;
                    end else begin
                        m_done = 1'b1;
                    end
                end
                1: begin
                    if (pp) begin
                        void'(exp_q.pop_front());
                        m_out++;
                    end
                    if (psh) begin
                        exp_q.push_back(y_data);
                        m_in++;
                    end
                    if (pp && exp_lst) begin
                        m_phase = 2; m_done = 1'b1;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        obs_data.delete();
        obs_last.delete();
        obs_cyc.delete();
        done_cyc = -1;
    endtask

    task automatic do_start(input logic [31:0] len);
        start = 1'b1;
        data_length = len;
        step();
        start = 1'b0;
    endtask

    // Offer one sample and hold it until the transmitter takes it.
    task automatic send(input logic [W-1:0] d);
        int n = 0;
        y_valid = 1'b1;
        y_data  = d;
        @(negedge clk);
        while (!y_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", {31'd0, (n < 100)}, 32'd1);
        step();
        y_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", {31'd0, (n < 200)}, 32'd1);
        step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        reset = 1'b0; start = 1'b0; data_length = '0;
        y_valid = 1'b0; y_data = '0; sm_tready = 1'b1;
        #2;
        chk("rst_sm_tdata", sm_tdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) step();
        reset = 1'b1;
        step();

        // Test 1: length 4, samples 1..4 back to back, ready held high.
        clear_log();
        do_start(32'd4);
        for (int i = 1; i <= 4; i++) send(W'(i));
        wait_done();
        chk("t1_beats", obs_data.size(), 32'd4);
        if (obs_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_data", obs_data[i], W'(i + 1));
                chk("t1_last", {31'd0, obs_last[i]}, (i == 3) ? 32'd1 : 32'd0);
                chk("t1_consec", obs_cyc[i] - obs_cyc[0], i);
            end
            chk("t1_done_cyc", done_cyc - obs_cyc[3], 32'd1);
        end

        // Test 2: length 3 with downstream stalled for five cycles.
        clear_log();
        sm_tready = 1'b0;
        do_start(32'd3);
        fork
            begin
                send(32'h10);
                send(32'h20);
                send(32'h30);
            end
            begin
                repeat (4) @(negedge clk);
                chk("t2_full_ready", {31'd0, y_ready}, 32'd0);
                chk("t2_hold_data", sm_tdata, 32'h10);
                chk("t2_hold_valid", {31'd0, sm_tvalid}, 32'd1);
                step();
                sm_tready = 1'b1;
            end
        join
        wait_done();
        chk("t2_beats", obs_data.size(), 32'd3);
        if (obs_data.size() == 3) begin
            chk("t2_b0", obs_data[0], 32'h10);
            chk("t2_b1", obs_data[1], 32'h20);
            chk("t2_b2", obs_data[2], 32'h30);
            chk("t2_last", {29'd0, obs_last[0], obs_last[1], obs_last[2]}, 32'd1);
        end

        // Test 3: zero-length start completes immediately without a frame.
        clear_log();
        do_start(32'd0);
        @(negedge clk);
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("t3_done_off", {31'd0, done}, 32'd0);
        step();
        chk("t3_no_beats", obs_data.size(), 32'd0);

        // Test 4: a second start during the frame is ignored.
        clear_log();
        do_start(32'd5);
        fork
            for (int i = 0; i < 5; i++) send(32'hA0 + W'(i));
            begin
                repeat (3) step();
                do_start(32'd9);
            end
        join
        wait_done();
        chk("t4_beats", obs_data.size(), 32'd5);
        if (obs_data.size() == 5) begin
            chk("t4_b4", obs_data[4], 32'hA4);
            chk("t4_last4", {31'd0, obs_last[4]}, 32'd1);
            chk("t4_last3", {31'd0, obs_last[3]}, 32'd0);
        end
        repeat (3) step();
        chk("t4_idle", {31'd0, busy}, 32'd0);

        // Test 5: reset mid-frame after two of six beats, then a fresh frame.
        clear_log();
        do_start(32'd6);
        send(32'h51);
        send(32'h52);
        send(32'h53);
        chk("t5_pre_beats", obs_data.size(), 32'd2);
        reset = 1'b0;
        #1;
        chk("t5_y_ready", {31'd0, y_ready}, 32'd0);
        chk("t5_tvalid", {31'd0, sm_tvalid}, 32'd0);
        chk("t5_tdata", sm_tdata, 32'd0);
        chk("t5_tlast", {31'd0, sm_tlast}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_err", {31'd0, err}, 32'd0);
        step();
        reset = 1'b1;
        step();
        clear_log();
        do_start(32'd2);
        send(32'h61);
        send(32'h62);
        wait_done();
        chk("t5_beats", obs_data.size(), 32'd2);
        if (obs_data.size() == 2) begin
            chk("t5_b0", obs_data[0], 32'h61);
            chk("t5_b1", obs_data[1], 32'h62);
            chk("t5_last", {30'd0, obs_last[0], obs_last[1]}, 32'd1);
        end

        // Test 6: sample offered while idle, then a new frame.
        clear_log();
        y_valid = 1'b1;
        y_data  = 32'hDEAD;
        step();
        y_valid = 1'b0;
        @(negedge clk);
        chk("t6_err_idle", {31'd0, err}, {31'd0, ERR_EN});
        chk("t6_no_beat", obs_data.size(), 32'd0);
        step();
        do_start(32'd1);
        @(negedge clk);
        chk("t6_err_clear", {31'd0, err}, 32'd0);
        step();
        send(32'h77);
        wait_done();
        chk("t6_beats", obs_data.size(), 32'd1);
        if (obs_data.size() == 1) begin
            chk("t6_b0", obs_data[0], 32'h77);
            chk("t6_last", {31'd0, obs_last[0]}, 32'd1);
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
